// File: rtl/frec_pkg.sv
// Shared constants for the frequency selector: widths, default debounce length
// and the eight-entry frequency code table.
package frec_pkg;
  localparam int FREC_IDX_W  = 3;
  localparam int FREC_W      = 8;
  localparam int FREC_N      = 8;
  localparam int DEB_CYC_DEF = 50000;

  typedef logic [FREC_IDX_W-1:0] frec_idx_t;
  typedef logic [FREC_W-1:0]     frec_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_e;

  localparam frec_idx_t FREC_IDX_MAX = FREC_IDX_W'(FREC_N - 1);

  localparam frec_t FREC_TABLE [FREC_N] = '{
    8'd30, 8'd50, 8'd75, 8'd100, 8'd125, 8'd150, 8'd175, 8'd200
  };

  function automatic frec_t frec_lookup(input frec_idx_t idx);
    return FREC_TABLE[idx];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted press (rising debounced level).
module btn_debounce
  import frec_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);
  localparam logic [15:0] CNT_MAX = 16'(DEB_CYC - 1);

  logic [1:0]  r_sync;
  logic        r_d;
  logic        r_d_prev;
  logic        r_press;
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_d      <= 1'b0;
      r_d_prev <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_btn};
      r_d_prev <= r_d;
      r_press  <= r_d & ~r_d_prev;
      // Any return to the debounced level restarts the stability window.
      if (r_sync[1] == r_d) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_d   <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/frec_selector.sv
// Up/down frequency selector: two debounced buttons step a saturating table
// index; the matching frequency code and a change pulse are registered.
module frec_selector
  import frec_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  output logic [FREC_W-1:0]     frecnum,
  output logic [FREC_IDX_W-1:0] frec_idx,
  output logic                  changed
);
  logic [1:0] w_btn;
  logic [1:0] w_press;
  step_e      w_step;
  frec_idx_t  w_idx_next;
  frec_idx_t  r_idx;
  frec_t      r_frecnum;
  logic       r_changed;

  assign w_btn = {btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYC (DEB_CYC)
      ) u_deb (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn   (w_btn[gi]),
        .o_press (w_press[gi])
      );
    end
  endgenerate

  // Simultaneous presses cancel; steps past either end are dropped.
  always_comb begin
    w_step = STEP_NONE;
    if (w_press[0] && !w_press[1] && r_idx != FREC_IDX_MAX) begin
      w_step = STEP_UP;
    end else if (w_press[1] && !w_press[0] && r_idx != '0) begin
      w_step = STEP_DOWN;
    end
  end

  always_comb begin
    w_idx_next = r_idx;
    case (w_step)
      STEP_UP:   w_idx_next = r_idx + 1'b1;
      STEP_DOWN: w_idx_next = r_idx - 1'b1;
      default:   w_idx_next = r_idx;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_frecnum <= frec_lookup('0);
      r_changed <= 1'b0;
    end else begin
      r_idx     <= w_idx_next;
      r_frecnum <= frec_lookup(w_idx_next);
      r_changed <= (w_step != STEP_NONE);
    end
  end

  assign frecnum  = r_frecnum;
  assign frec_idx = r_idx;
  assign changed  = r_changed;
endmodule

// File: tb/tb_frec_selector.sv
// Directed bench for frec_selector with DEB_CYC=4; expected steps are queued
// with their due cycle and compared every cycle against the outputs.
module tb_frec_selector;
  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] frecnum;
  logic [2:0] frec_idx;
  logic       changed;

  frec_selector #(.DEB_CYC(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .frecnum  (frecnum),
    .frec_idx (frec_idx),
    .changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] frec;
    logic [2:0] idx;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] tbl [8] = '{8'd30, 8'd50, 8'd75, 8'd100, 8'd125, 8'd150, 8'd175, 8'd200};
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         model_idx = 0;
  logic [7:0] exp_frec;
  logic [2:0] exp_idx;
  logic       exp_chg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("frecnum", {24'b0, frecnum}, {24'b0, exp_frec});
    chk("frec_idx", {29'b0, frec_idx}, {29'b0, exp_idx});
    chk("changed", {31'b0, changed}, {31'b0, exp_chg});
  endtask

  // One clock: pop the step due on this edge (if any), then compare.
  task automatic tick();
    ev_t ev;
    @(posedge clk);
    cyc++;
    #1;
    exp_chg = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev = sb.pop_front();
      exp_frec = ev.frec;
      exp_idx  = ev.idx;
      exp_chg  = 1'b1;
    end
    check_outputs();
  endtask

  // A clean edge driven now is first sampled on the next edge and must show
  // up DEB_CYC+3 = 7 edges after that sample.
  task automatic sched(input int dir);
    ev_t ev;
    if (dir > 0 && model_idx < 7) model_idx++;
    else if (dir < 0 && model_idx > 0) model_idx--;
    else return;
    ev.due  = cyc + 8;
    ev.frec = tbl[model_idx];
    ev.idx  = 3'(model_idx);
    sb.push_back(ev);
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    btn_up   = up;
    btn_down = dn;
    if (up && !dn) sched(1);
    else if (dn && !up) sched(-1);
    repeat (hold) tick();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (10) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    model_idx = 0;
    exp_frec  = 8'd30;
    exp_idx   = 3'd0;
    exp_chg   = 1'b0;
    #1;
    check_outputs();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    #1;
    do_reset();

    // Idle after reset release
    repeat (100) tick();

    // Long clean hold: one step with exact latency, no repeat
    press(1'b1, 1'b0, 20);

    // Bouncy press then stable
    do_reset();
    btn_up = 1'b1; repeat (2) tick();
    btn_up = 1'b0; repeat (2) tick();
    btn_up = 1'b1; repeat (2) tick();
    btn_up = 1'b0; repeat (2) tick();
    press(1'b1, 1'b0, 10);

    // Climb to the top and saturate, then descend and saturate
    do_reset();
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 10);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 10);

    // Simultaneous presses cancel
    do_reset();
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b1, 10);

    // Reset in the middle of a debounce window
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10);
    btn_up = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    sb.delete();
    model_idx = 0;
    exp_frec  = 8'd30;
    exp_idx   = 3'd0;
    exp_chg   = 1'b0;
    #1;
    check_outputs();
    tick();
    reset = 1'b1;
    sched(1);
    repeat (12) tick();
    btn_up = 1'b0;
    repeat (10) tick();

    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frec_selector.md
FREC_SELECTOR -- requirements
Module: frec_selector

Interface
REQ-001 Parameter DEB_CYC, default 50000, consecutive clk cycles a synchronized button level must differ from the debounced level before it is accepted; legal range 2..65535.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-004 btn_up  input  1  raw push-button, active-high, asynchronous to clk, bouncy.
REQ-005 btn_down  input  1  raw push-button, active-high, asynchronous to clk, bouncy.
REQ-006 frecnum  output  8  selected frequency code, registered, drives the divider's frecnum input.
REQ-007 frec_idx  output  3  current table index 0..7, registered.
REQ-008 changed  output  1  one-cycle pulse when frecnum takes a new value.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Per button: debounced level d and 16-bit counter cnt; if sync==d then cnt<=0; else cnt<=cnt+1, and when cnt==DEB_CYC-1 then d<=sync, cnt<=0.
REQ-011 A press event SHALL be a rising edge of d (d=1, previous d=0), one cycle wide; releases generate no event.
REQ-012 Up event alone with frec_idx<7: frec_idx<=frec_idx+1, changed=1 next cycle.
REQ-013 Down event alone with frec_idx>0: frec_idx<=frec_idx-1, changed=1 next cycle.
REQ-014 Saturation: up at idx 7 or down at idx 0 SHALL leave idx unchanged and changed=0; no wrap-around.
REQ-015 Up and down events in the same cycle SHALL cancel: no index change, changed=0.
REQ-016 frecnum SHALL be a registered lookup of frec_idx: 0->30, 1->50, 2->75, 3->100, 4->125, 5->150, 6->175, 7->200, updated in the same edge as frec_idx.
REQ-017 frecnum SHALL only ever hold one of the eight table values, never an intermediate or default code.
REQ-018 Latency: a clean level change on btn_up held stable SHALL update frecnum exactly DEB_CYC+3 clk edges after first sampled by the synchronizer's first flop.
REQ-019 A pulse shorter than DEB_CYC cycles (bounce) SHALL produce no event; any return to d level resets cnt to 0.
REQ-020 Holding a button SHALL produce exactly one step; no auto-repeat.

Reset
REQ-021 While reset=0: frec_idx=0, frecnum=30, changed=0, synchronizer flops=0, d=0, cnt=0.
REQ-022 Reset asserted mid-debounce SHALL discard the pending count; after release a held button must be stable DEB_CYC cycles and yields one event.
REQ-023 Reset release SHALL be the only way to return to idx 0 other than stepping down.

Structure
REQ-024 Shared package frec_pkg SHALL hold the 8-entry frequency table constants, FREC_IDX_W=3, FREC_W=8, and DEB_CYC default.
REQ-025 One sub-module btn_debounce (synchronizer, debounce counter, rising-edge pulse, parameter DEB_CYC) SHALL be instantiated twice.
REQ-026 Top level holds the index register, saturation/cancel logic, lookup register and changed pulse.

Verification (DEB_CYC=4)
REQ-027 Reset release, no buttons -> frecnum=30, frec_idx=0, changed=0 for 100 cycles.
REQ-028 btn_up high for 20 cycles -> frecnum=50 at exactly edge 7 after first sample, changed high one cycle, no further step while held.
REQ-029 btn_up bounce 1,0,1,0 with 2-cycle pulses then stable 10 cycles -> exactly one step 30->50.
REQ-030 Eight clean up presses from idx 0 -> sequence 50..200 then holds 200, changed absent on 8th; symmetric down presses to 30 and saturate.
REQ-031 btn_up and btn_down rise in the same cycle, held 10 cycles -> no change, changed=0.
REQ-032 At idx 3 (100), reset=0 for 1 cycle mid-debounce of btn_up -> frecnum=30 immediately; held button yields one step to 50 after DEB_CYC+3 edges post-release.
